// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO feeding an 8N1 serializer on tx.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_TC = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              baud_tc;
  logic              bypass;
  logic              push;
  logic              pop;
  logic [7:0]        head;

  // Status decode and FIFO handshake, all from pre-edge state.
  // An idle controller with an empty FIFO launches a written byte straight
  // into the shifter so the start bit appears the cycle after the write.
  always_comb begin
    baud_tc    = (baud_cnt == BAUD_TC);
    fifo_full  = (count == DEPTH_C);
    fifo_empty = (count == '0);
    busy       = (state != IDLE) | ~fifo_empty;
    bypass     = (state == IDLE) && fifo_empty && wr_en;
    pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_tc));
    push       = wr_en && !fifo_full && !bypass;
    head       = mem[rd_ptr];
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a dropped write beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_en && fifo_full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Frame serializer: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (!fifo_empty) begin
            shift <= head;
            state <= START;
            tx    <= 1'b0;
          end else if (wr_en) begin
            shift <= wr_data;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              shift <= head;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
